// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator datapath: state bus encoding and floor geometry.
// The floor counter decodes the same IDLE/MOVE_UP/MOVE_DOWN/DOOR_OPEN values.
package elevator_pkg;

  localparam int FLOOR_W    = 2;
  localparam int NUM_FLOORS = 4;

  localparam logic [1:0] IDLE      = 2'b00;
  localparam logic [1:0] MOVE_UP   = 2'b01;
  localparam logic [1:0] MOVE_DOWN = 2'b10;
  localparam logic [1:0] DOOR_OPEN = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE      = IDLE,
    ST_MOVE_UP   = MOVE_UP,
    ST_MOVE_DOWN = MOVE_DOWN,
    ST_DOOR_OPEN = DOOR_OPEN
  } state_e;

  function automatic logic [NUM_FLOORS-1:0] floor_onehot(input logic [FLOOR_W-1:0] f);
    return NUM_FLOORS'(1) << f;
  endfunction

endpackage

// File: rtl/elevator_req_reg.sv
// Outstanding call register with set/clear logic and the position-relative reductions
// (requests above, below and at the current floor) used by the controller.
module elevator_req_reg
  import elevator_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_FLOORS-1:0] floor_req_i,
  input  logic [FLOOR_W-1:0]    curr_floor_i,
  input  logic                  clr_en_i,
  output logic [NUM_FLOORS-1:0] pending_o,
  output logic                  above_o,
  output logic                  below_o,
  output logic                  here_o
);

  logic [NUM_FLOORS-1:0] pending_q, pending_d;
  logic [NUM_FLOORS-1:0] clr_mask, above_mask, below_mask;

  // Clear beats set so a call at the serviced floor is absorbed, never latched.
  always_comb begin
    clr_mask   = clr_en_i ? floor_onehot(curr_floor_i) : '0;
    pending_d  = (pending_q | floor_req_i) & ~clr_mask;
    above_mask = '0;
    below_mask = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      above_mask[i] = (i > int'(curr_floor_i));
      below_mask[i] = (i < int'(curr_floor_i));
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign pending_o = pending_q;
  assign above_o   = |(pending_q & above_mask);
  assign below_o   = |(pending_q & below_mask);
  assign here_o    = pending_q[curr_floor_i] | floor_req_i[curr_floor_i];

endmodule

// File: rtl/elevator_ctrl_fsm.sv
// Elevator master controller: SCAN motion decisions, door dwell timer and direction
// preference. Floor count is fixed by elevator_pkg to match the 2-bit floor bus.
module elevator_ctrl_fsm
  import elevator_pkg::*;
#(
  parameter int DOOR_TIME = 100,
  parameter int TIMER_W   = 7
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_FLOORS-1:0] floor_req,
  input  logic [FLOOR_W-1:0]    curr_floor,
  output logic [1:0]            current_state,
  output logic                  door_open,
  output logic                  dir_up,
  output logic [NUM_FLOORS-1:0] pending_req
);

  localparam logic [TIMER_W-1:0] DWELL_LAST = TIMER_W'(DOOR_TIME - 1);
  localparam logic [FLOOR_W-1:0] TOP_FLOOR  = FLOOR_W'(NUM_FLOORS - 1);

  state_e                state_q, state_d;
  logic [TIMER_W-1:0]    timer_q, timer_d;
  logic                  dir_q, dir_d;
  logic                  door_q;
  logic [FLOOR_W-1:0]    prev_floor_q;
  logic [NUM_FLOORS-1:0] pending;
  logic                  above, below, here;
  logic                  arrived, clr_en;

  assign arrived = (curr_floor != prev_floor_q);
  assign clr_en  = (state_d == ST_DOOR_OPEN) || (state_q == ST_DOOR_OPEN);

  elevator_req_reg u_req_reg (
    .clk          (clk),
    .reset_n      (reset_n),
    .floor_req_i  (floor_req),
    .curr_floor_i (curr_floor),
    .clr_en_i     (clr_en),
    .pending_o    (pending),
    .above_o      (above),
    .below_o      (below),
    .here_o       (here)
  );

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    timer_d = timer_q;
    case (state_q)
      ST_IDLE: begin
        if (here) begin
          state_d = ST_DOOR_OPEN;
          timer_d = '0;
        end else if (above && (dir_q || !below)) begin
          state_d = ST_MOVE_UP;
          dir_d   = 1'b1;
        end else if (below) begin
          state_d = ST_MOVE_DOWN;
          dir_d   = 1'b0;
        end
      end
      // Stops are only considered on the cycle the floor bus changes, so a call at
      // the departure floor cannot hold the car in place.
      ST_MOVE_UP: begin
        if (arrived) begin
          if (pending[curr_floor]) begin
            state_d = ST_DOOR_OPEN;
            timer_d = '0;
          end else if (curr_floor == TOP_FLOOR) begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_MOVE_DOWN: begin
        if (arrived) begin
          if (pending[curr_floor]) begin
            state_d = ST_DOOR_OPEN;
            timer_d = '0;
          end else if (curr_floor == '0) begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DOOR_OPEN: begin
        if (floor_req[curr_floor]) begin
          timer_d = '0;
        end else if (timer_q == DWELL_LAST) begin
          timer_d = '0;
          if (dir_q && above) begin
            state_d = ST_MOVE_UP;
          end else if (!dir_q && below) begin
            state_d = ST_MOVE_DOWN;
          end else if (above) begin
            state_d = ST_MOVE_UP;
            dir_d   = 1'b1;
          end else if (below) begin
            state_d = ST_MOVE_DOWN;
            dir_d   = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      dir_q        <= 1'b1;
      timer_q      <= '0;
      door_q       <= 1'b0;
      prev_floor_q <= curr_floor;
    end else begin
      state_q      <= state_d;
      dir_q        <= dir_d;
      timer_q      <= timer_d;
      door_q       <= (state_d == ST_DOOR_OPEN);
      prev_floor_q <= curr_floor;
    end
  end

  assign current_state = state_q;
  assign door_open     = door_q;
  assign dir_up        = dir_q;
  assign pending_req   = pending;

endmodule

// File: tb/tb_elevator_ctrl_fsm.sv
// Directed bench for elevator_ctrl_fsm: the bench plays the floor counter by driving
// curr_floor, and checks state/door/direction/pending against hand-computed values.
module tb_elevator_ctrl_fsm;
  import elevator_pkg::*;

  localparam int DT = 100;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] floor_req = '0;
  logic [1:0] curr_floor = '0;
  logic [1:0] current_state;
  logic       door_open;
  logic       dir_up;
  logic [3:0] pending_req;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic       rst_n;
    logic [3:0] req;
    logic [1:0] cf;
    logic [1:0] e_st;
    logic       e_door;
    logic       e_dir;
    logic [3:0] e_pend;
  } vec_t;

  vec_t vecs[8];

  always #5 clk = ~clk;

  elevator_ctrl_fsm #(.DOOR_TIME(DT), .TIMER_W(7)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .floor_req     (floor_req),
    .curr_floor    (curr_floor),
    .current_state (current_state),
    .door_open     (door_open),
    .dir_up        (dir_up),
    .pending_req   (pending_req)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic [3:0] q, input logic [1:0] f);
    reset_n    = r;
    floor_req  = q;
    curr_floor = f;
  endtask

  task automatic chk_out(input string name, input logic [1:0] st, input logic door,
                         input logic dir, input logic [3:0] pend);
    logic [7:0] act;
    logic [7:0] want;
    act  = {current_state, door_open, dir_up, pending_req};
    want = {st, door, dir, pend};
    n_checks++;
    if (act === want) n_pass++;
    else $display("FAIL %s: state/door/dir/pend got %b_%b_%b_%b want %b_%b_%b_%b", name,
                  act[7:6], act[5], act[4], act[3:0], want[7:6], want[5], want[4], want[3:0]);
  endtask

  task automatic chk_cnt(input string name, input int act, input int want);
    n_checks++;
    if (act == want) n_pass++;
    else $display("FAIL %s: got %0d want %0d", name, act, want);
  endtask

  // Counts DOOR_OPEN samples until the door closes; 'already' samples were seen by the caller.
  task automatic dwell(input string name, input int already, input int want_len);
    int n;
    n = already;
    for (int k = 0; k < 400; k++) begin
      step();
      if (current_state != DOOR_OPEN) break;
      n++;
    end
    chk_cnt(name, n, want_len);
  endtask

  initial begin
    vecs[0] = '{1'b0, 4'b0000, 2'd0, IDLE,      1'b0, 1'b1, 4'b0000};
    vecs[1] = '{1'b1, 4'b0100, 2'd0, IDLE,      1'b0, 1'b1, 4'b0100};
    vecs[2] = '{1'b1, 4'b0000, 2'd0, MOVE_UP,   1'b0, 1'b1, 4'b0100};
    vecs[3] = '{1'b1, 4'b0001, 2'd0, MOVE_UP,   1'b0, 1'b1, 4'b0101};
    vecs[4] = '{1'b1, 4'b0000, 2'd1, MOVE_UP,   1'b0, 1'b1, 4'b0101};
    vecs[5] = '{1'b1, 4'b0000, 2'd1, MOVE_UP,   1'b0, 1'b1, 4'b0101};
    vecs[6] = '{1'b1, 4'b0000, 2'd2, DOOR_OPEN, 1'b1, 1'b1, 4'b0001};
    vecs[7] = '{1'b1, 4'b0000, 2'd2, DOOR_OPEN, 1'b1, 1'b1, 4'b0001};

    drive(1'b0, 4'b0000, 2'd0);
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].rst_n, vecs[i].req, vecs[i].cf);
      step();
      chk_out($sformatf("vec%0d", i), vecs[i].e_st, vecs[i].e_door, vecs[i].e_dir, vecs[i].e_pend);
    end

    // Dwell extension at floor 2: re-press at timer 90 restarts the full dwell.
    repeat (89) step();
    chk_out("pre_ext", DOOR_OPEN, 1'b1, 1'b1, 4'b0001);
    drive(1'b1, 4'b0100, 2'd2);
    step();
    chk_out("ext_absorb", DOOR_OPEN, 1'b1, 1'b1, 4'b0001);
    drive(1'b1, 4'b0000, 2'd2);
    dwell("ext_dwell", 92, 91 + DT);
    chk_out("turn_down", MOVE_DOWN, 1'b0, 1'b0, 4'b0001);
    drive(1'b1, 4'b0000, 2'd1);
    step();
    chk_out("down_pass1", MOVE_DOWN, 1'b0, 1'b0, 4'b0001);
    drive(1'b1, 4'b0000, 2'd0);
    step();
    chk_out("down_stop0", DOOR_OPEN, 1'b1, 1'b0, 4'b0000);
    dwell("dwell0", 1, DT);
    chk_out("idle0", IDLE, 1'b0, 1'b0, 4'b0000);

    // Call at the car's own floor while idle.
    drive(1'b1, 4'b0001, 2'd0);
    step();
    chk_out("own_call", DOOR_OPEN, 1'b1, 1'b0, 4'b0000);
    drive(1'b1, 4'b0000, 2'd0);
    dwell("own_dwell", 1, DT);
    chk_out("own_idle", IDLE, 1'b0, 1'b0, 4'b0000);

    // Simultaneous calls above and below from floor 1 with dir_up=0.
    drive(1'b1, 4'b1001, 2'd1);
    step();
    chk_out("sim_latch", IDLE, 1'b0, 1'b0, 4'b1001);
    drive(1'b1, 4'b0000, 2'd1);
    step();
    chk_out("sim_down", MOVE_DOWN, 1'b0, 1'b0, 4'b1001);
    drive(1'b1, 4'b0000, 2'd0);
    step();
    chk_out("sim_stop0", DOOR_OPEN, 1'b1, 1'b0, 4'b1000);
    dwell("sim_dwell", 1, DT);
    chk_out("sim_up", MOVE_UP, 1'b0, 1'b1, 4'b1000);
    drive(1'b1, 4'b0000, 2'd1);
    step();
    chk_out("sim_up1", MOVE_UP, 1'b0, 1'b1, 4'b1000);

    // Reset while moving up with a request outstanding.
    drive(1'b0, 4'b0000, 2'd1);
    step();
    chk_out("rst_move", IDLE, 1'b0, 1'b1, 4'b0000);

    // SCAN: door at floor 1 heading up, calls at 3 and 0.
    drive(1'b1, 4'b1011, 2'd1);
    step();
    chk_out("scan_open1", DOOR_OPEN, 1'b1, 1'b1, 4'b1001);
    drive(1'b1, 4'b0000, 2'd1);
    dwell("scan_dwell1", 1, DT);
    chk_out("scan_up", MOVE_UP, 1'b0, 1'b1, 4'b1001);
    drive(1'b1, 4'b0000, 2'd2);
    step();
    chk_out("scan_pass2", MOVE_UP, 1'b0, 1'b1, 4'b1001);
    drive(1'b1, 4'b0000, 2'd3);
    step();
    chk_out("scan_stop3", DOOR_OPEN, 1'b1, 1'b1, 4'b0001);
    dwell("scan_dwell3", 1, DT);
    chk_out("scan_down", MOVE_DOWN, 1'b0, 1'b0, 4'b0001);
    for (int f = 2; f >= 1; f--) begin
      drive(1'b1, 4'b0000, 2'(f));
      step();
      chk_out($sformatf("scan_pass_f%0d", f), MOVE_DOWN, 1'b0, 1'b0, 4'b0001);
    end
    drive(1'b1, 4'b0000, 2'd0);
    step();
    chk_out("scan_stop0", DOOR_OPEN, 1'b1, 1'b0, 4'b0000);

    // Reset in the middle of a dwell.
    drive(1'b0, 4'b0000, 2'd0);
    step();
    chk_out("rst_dwell", IDLE, 1'b0, 1'b1, 4'b0000);

    // Floor bus jumps to the top floor with no call there: defensive return to IDLE.
    drive(1'b1, 4'b0100, 2'd0);
    step();
    chk_out("end_latch", IDLE, 1'b0, 1'b1, 4'b0100);
    drive(1'b1, 4'b0000, 2'd0);
    step();
    chk_out("end_up", MOVE_UP, 1'b0, 1'b1, 4'b0100);
    drive(1'b1, 4'b0000, 2'd3);
    step();
    chk_out("end_idle", IDLE, 1'b0, 1'b1, 4'b0100);
    step();
    chk_out("end_down", MOVE_DOWN, 1'b0, 1'b0, 4'b0100);
    drive(1'b1, 4'b0000, 2'd2);
    step();
    chk_out("end_stop2", DOOR_OPEN, 1'b1, 1'b0, 4'b0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/elevator_ctrl_fsm.md
Name: elevator_ctrl_fsm

Overview:
- Master controller of the elevator datapath. Latches hall/car call requests and decides motion.
- Drives the 2-bit state bus that the floor counter consumes, and consumes the floor counter's curr_floor as position feedback.
- Owns door dwell timing and direction preference (SCAN: continue the current direction while requests remain ahead).

Parameters:
- NUM_FLOORS, 4, floor count; fixed to 4 to match the 2-bit floor bus.
- DOOR_TIME, 100, DOOR_OPEN dwell in clk cycles; legal range 2..(2^TIMER_W)-1.
- TIMER_W, 7, door timer width.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous active-low reset.
- floor_req  in  4  one-hot-per-floor call pulses; several bits may be set in one cycle.
- curr_floor  in  2  position from the floor counter.
- current_state  out  2  state bus: IDLE=00, MOVE_UP=01, MOVE_DOWN=10, DOOR_OPEN=11.
- door_open  out  1  high iff current_state==DOOR_OPEN.
- dir_up  out  1  direction preference; 1=up.
- pending_req  out  4  latched outstanding requests.

Behaviour:
- Reset (reset_n low at a clk edge): current_state=IDLE, pending_req=0, dir_up=1, door timer=0, prev_floor<=curr_floor. Reset overrides every event, including mid-move and mid-dwell.
- All outputs are registered. A decision is visible on current_state one cycle after its inputs are sampled.
- Request latching:
  - Each cycle: pending_req <= (pending_req | floor_req) & ~clr_mask.
  - clr_mask = one-hot(curr_floor) while the next state is DOOR_OPEN or the current state is DOOR_OPEN. Clear wins over set.
- Derived signals:
  - above = OR(pending bits for floors > curr_floor).
  - below = OR(pending bits for floors < curr_floor).
  - here = pending[curr_floor] | floor_req[curr_floor].
  - arrived = (curr_floor != prev_floor). prev_floor is registered every cycle.
- IDLE:
  - here -> DOOR_OPEN.
  - else above & (dir_up | ~below) -> MOVE_UP, dir_up=1.
  - else below -> MOVE_DOWN, dir_up=0.
  - else stay.
  - here has priority over above/below.
- MOVE_UP / MOVE_DOWN:
  - Stop decisions are made only on the arrived cycle. Requests at the departure floor never stop the car before it moves.
  - On arrived with pending[curr_floor] -> DOOR_OPEN.
  - On arrived with the car at an end floor (3 for up, 0 for down) and no request there -> IDLE. This is a defensive case; it cannot occur with correct request logic.
  - Otherwise hold the state. The floor counter advances the floor.
- Entering DOOR_OPEN: door timer loads 0.
- DOOR_OPEN:
  - Timer increments each cycle.
  - floor_req[curr_floor] during dwell is absorbed and reloads the timer to 0 (door re-open extension).
  - When timer==DOOR_TIME-1, choose the next state: (dir_up & above) -> MOVE_UP; (~dir_up & below) -> MOVE_DOWN; else above -> MOVE_UP with dir_up=1; else below -> MOVE_DOWN with dir_up=0; else IDLE.
  - Never goes MOVE_UP from floor 3 or MOVE_DOWN from floor 0; this follows from the above/below definitions.
- Simultaneous requests above and below while IDLE resolve by dir_up.
- Invariant: never in MOVE_* with pending_req==0, except after an arrival at the end floor. The assertion target allows one cycle of slack for that case.

Decomposition:
- Shared package elevator_pkg:
  - state localparams IDLE/MOVE_UP/MOVE_DOWN/DOOR_OPEN (also used by the floor counter);
  - FLOOR_W=2, NUM_FLOORS=4.
- One natural sub-module, elevator_req_reg: holds the pending register, the set/clear logic and the above/below/here reductions.
- The FSM, door timer and direction register stay in elevator_ctrl_fsm.

Test Plan:
- Reset mid-move: MOVE_UP with pending=1000, reset_n low for 1 cycle -> next cycle state=00, pending=0000, dir_up=1.
- Idle call at own floor: curr_floor=0, floor_req=0001 for 1 cycle -> state=11 next cycle; pending[0] stays 0; after DOOR_TIME cycles -> state=00.
- Single upward trip: curr_floor=0, floor_req=0100 -> MOVE_UP; drive curr_floor 0->1 (no stop, state=01), 1->2 -> state=11 the cycle after arrival; pending=0000.
- SCAN preference: at floor 1 going up with dwell ending, pending=1001 -> MOVE_UP (dir_up=1); after the stop at 3 and its dwell -> MOVE_DOWN to floor 0.
- Dwell extension: in DOOR_OPEN at floor 2, floor_req=0100 at timer=90 -> door remains open a further DOOR_TIME cycles; pending[2]=0 throughout.
- Simultaneous: IDLE at floor 1, dir_up=0, floor_req=1001 -> MOVE_DOWN; floor 0 serviced first, then MOVE_UP to floor 3.
